// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    VALID,
    DISCARD,
    HALT
  } fetch_state_t;

  localparam logic [31:0] RV_NOP  = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack and hands
// words to decode over valid/ready. Redirects from execute squash stale fetches;
// a misaligned redirect target sets a sticky fault and parks the stage in HALT.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | just out of reset, nothing requested yet
// WAIT    | imem_req high at pc, waiting for imem_ack
// VALID   | instruction held on idata/iaddr until instr_ready
// DISCARD | old request still in flight; its data is dropped on ack
// HALT    | misaligned redirect seen; stays here until reset
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] idata,
  output logic [XLEN-1:0] iaddr,
  output logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fault,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] idata_q, idata_d;
  logic [XLEN-1:0] iaddr_q, iaddr_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic            halt_pend_q, halt_pend_d;
  logic            misalign;

  assign misalign = (redirect_pc[1:0] != 2'b00);

  // Next-state, next-PC mux and handshake bookkeeping.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    idata_d     = idata_q;
    iaddr_d     = iaddr_q;
    fault_d     = fault_q;
    halt_pend_d = halt_pend_q;
    count_d     = count_q;

    // Every valid&&ready handshake counts, including one that coincides with a redirect.
    if (valid_q && instr_ready) begin
      count_d = count_q + 1'b1;
    end

    unique case (state_q)
      IDLE: state_d = WAIT;

      WAIT: begin
        if (redirect_valid) begin
          if (misalign) begin
            fault_d = 1'b1;
            if (imem_ack) begin
              state_d = HALT;
            end else begin
              state_d     = DISCARD;
              halt_pend_d = 1'b1;
            end
          end else begin
            pc_d    = redirect_pc;
            state_d = imem_ack ? WAIT : DISCARD;
          end
        end else if (imem_ack) begin
          idata_d = imem_rdata;
          iaddr_d = pc_q;
          state_d = VALID;
        end
      end

      VALID: begin
        if (redirect_valid) begin
          if (misalign) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = redirect_pc;
            state_d = WAIT;
          end
        end else if (instr_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = WAIT;
        end
      end

      DISCARD: begin
        if (redirect_valid) begin
          if (misalign) begin
            fault_d     = 1'b1;
            halt_pend_d = 1'b1;
          end else begin
            pc_d = redirect_pc;
          end
        end
        // The in-flight request finishes on this ack even if a redirect arrives with it.
        if (imem_ack) begin
          state_d = halt_pend_d ? HALT : WAIT;
        end
      end

      HALT: state_d = HALT;

      default: state_d = IDLE;
    endcase

    valid_d = (state_d == VALID);
    // The request address follows pc only when a new request starts; in DISCARD it keeps the old one.
    addr_d  = (state_d == WAIT) ? pc_d : addr_q;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      idata_q     <= RV_NOP;
      iaddr_q     <= RESET_PC;
      count_q     <= '0;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      idata_q     <= idata_d;
      iaddr_q     <= iaddr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign imem_req    = (state_q == WAIT) || (state_q == DISCARD);
  assign imem_addr   = {addr_q[XLEN-1:2], 2'b00};
  assign instr_valid = valid_q;
  assign idata       = idata_q;
  assign iaddr       = iaddr_q;
  assign pc          = pc_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model with programmable ack latency,
// expected handoffs queued when ready is driven and checked by a monitor.
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] idata;
  logic [31:0] iaddr;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fetch_count;

  int   errors = 0;
  int   checks = 0;
  int   lat    = 0;
  int   cnt;
  exp_t exp_q[$];

  instr_fetch #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .idata         (idata),
    .iaddr         (iaddr),
    .pc            (pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fault         (fault),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0) return 32'h1F40_0293;
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory: ack once the request has been held for lat cycles (lat=0 -> same cycle).
  always @(posedge clk or posedge reset) begin
    if (reset) cnt <= 0;
    else if (imem_req && !imem_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end
  assign imem_ack   = imem_req && (cnt >= lat);
  assign imem_rdata = memfn(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL handoff_unexpected: got iaddr %h with nothing expected", iaddr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("handoff_iaddr", iaddr, e.addr);
        chk("handoff_idata", idata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw_valid;
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick();
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_idata", idata, 32'h0000_0013);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_pc", pc, 32'h0);

    // Zero-wait fetch of address 0, then consumer stalls for 5 cycles.
    reset = 1'b0;
    tick();
    chk("t1_req", {31'b0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_ack", {31'b0, imem_ack}, 32'd1);
    tick();
    chk("t1_valid", {31'b0, instr_valid}, 32'd1);
    chk("t1_iaddr", iaddr, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_idata", idata, 32'h1F40_0293);
      chk("t2_hold_iaddr", iaddr, 32'h0);
      chk("t2_req_low", {31'b0, imem_req}, 32'd0);
      tick();
    end
    exp_q.push_back('{addr: 32'h0, data: 32'h1F40_0293});
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t2_next_addr", imem_addr, 32'h4);
    chk("t2_count", fetch_count, 32'd1);
    chk("t2_valid_low", {31'b0, instr_valid}, 32'd0);
    tick();
    chk("t2b_iaddr", iaddr, 32'h4);

    // Slow memory: redirect to 0x100 while a request to 0x8 is pending.
    lat = 3;
    exp_q.push_back('{addr: 32'h4, data: memfn(32'h4)});
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t3_count", fetch_count, 32'd2);
    chk("t3_addr_before", imem_addr, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("t3_pc_target", pc, 32'h100);
    chk("t3_addr_held", imem_addr, 32'h8);
    chk("t3_req_held", {31'b0, imem_req}, 32'd1);
    saw_valid = 1'b0;
    n = 0;
    while (!imem_ack && n < 10) begin
      if (instr_valid) saw_valid = 1'b1;
      tick();
      n++;
    end
    chk("t3_ack_seen", {31'b0, imem_ack}, 32'd1);
    chk("t3_addr_at_ack", imem_addr, 32'h8);
    tick();
    chk("t3_new_addr", imem_addr, 32'h100);
    n = 0;
    while (!instr_valid && n < 10) begin
      tick();
      n++;
    end
    chk("t3_no_stale_valid", {31'b0, saw_valid}, 32'd0);
    chk("t3_valid", {31'b0, instr_valid}, 32'd1);
    chk("t3_iaddr", iaddr, 32'h100);

    // Redirect to 0x200 in the same cycle the consumer accepts.
    lat = 0;
    exp_q.push_back('{addr: 32'h100, data: memfn(32'h100)});
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    chk("t4_count", fetch_count, 32'd3);
    chk("t4_addr", imem_addr, 32'h200);
    chk("t4_valid_low", {31'b0, instr_valid}, 32'd0);
    tick();
    chk("t4_iaddr", iaddr, 32'h200);
    chk("t4_idata", idata, memfn(32'h200));

    // Misaligned redirect from VALID halts the stage.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
    chk("t5_fault", {31'b0, fault}, 32'd1);
    chk("t5_valid", {31'b0, instr_valid}, 32'd0);
    chk("t5_pc_kept", pc, 32'h200);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_req_low", {31'b0, imem_req}, 32'd0);
    end
    reset = 1'b1;
    #1;
    chk("t5_rst_fault", {31'b0, fault}, 32'd0);
    chk("t5_rst_pc", pc, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("t5_restart_addr", imem_addr, 32'h0);
    chk("t5_restart_req", {31'b0, imem_req}, 32'd1);

    // Redirect to the top word, accept it, and wrap to 0.
    tick();
    exp_q.push_back('{addr: 32'h0, data: 32'h1F40_0293});
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("t6_count", fetch_count, 32'd1);
    tick();
    exp_q.push_back('{addr: 32'hFFFF_FFFC, data: memfn(32'hFFFF_FFFC)});
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t6_wrap_addr", imem_addr, 32'h0);
    chk("t6_wrap_pc", pc, 32'h0);
    chk("t6_count2", fetch_count, 32'd2);

    // Asynchronous reset while a request is up.
    chk("t7_req_before", {31'b0, imem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t7_req_async", {31'b0, imem_req}, 32'd0);

    // Misaligned redirect while a slow request is outstanding: finish it, then halt.
    lat = 2;
    tick();
    reset = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    tick();
    redirect_valid = 1'b0;
    chk("t8_fault", {31'b0, fault}, 32'd1);
    chk("t8_req_held", {31'b0, imem_req}, 32'd1);
    chk("t8_addr_held", imem_addr, 32'h0);
    n = 0;
    while (!imem_ack && n < 10) begin
      tick();
      n++;
    end
    chk("t8_ack_seen", {31'b0, imem_ack}, 32'd1);
    tick();
    chk("t8_req_low", {31'b0, imem_req}, 32'd0);
    chk("t8_valid_low", {31'b0, instr_valid}, 32'd0);
    chk("t8_pc_kept", pc, 32'h0);

    tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
